irq_pending_latch: RTL and testbench
====================================

Name: irq_pending_latch

Overview:
- Upstream stage of the 8-to-3 priority encoder.
- Synchronises 8 asynchronous request lines, detects events, and holds them as sticky pending bits under a software mask.
- Presents the masked pending vector as the encoder's 8-bit input.
- The consumer returns the encoded 3-bit index on an acknowledge port to retire the serviced request.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per request line (legal 2..4).
- LEVEL_MODE, 0, 0 = rising-edge capture with sticky pending; 1 = pending tracks synchronised level, and ack has no effect on it.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears state immediately, deassertion synchronous to clk by system.
- req_in  input  8  asynchronous request lines, bit 7 highest priority downstream.
- mask_wr  input  1  one-cycle pulse, loads mask_din into mask.
- mask_din  input  8  new mask value; 1 = masked.
- ack_valid  input  1  one-cycle pulse, request ack_idx serviced.
- ack_idx  input  3  binary index of serviced line (encoder output).
- pend_vec  output  8  pending & ~mask, feeds encoder input.
- irq  output  1  OR-reduce of pend_vec.
- ack_err  output  1  one-cycle pulse, ack to a non-pending or masked line.
- mask_q  output  8  current mask register.

Behaviour:
- Reset values:
  - sync chains, edge history and pending: 8'h00.
  - mask: 8'hFF (all masked).
  - pend_vec: 8'h00; irq: 0; ack_err: 0.
- Synchroniser: SYNC_STAGES flops per bit. Edge history register holds the last synchronised value.
- Edge mode (LEVEL_MODE=0):
  - Rising edge on synchronised bit i sets pending[i] on the same clk edge the history updates.
  - Latency: req_in rise to pending/pend_vec/irq high = SYNC_STAGES+1 clk edges.
- A line already high when rst_n deasserts counts as one rising edge, since history resets to 0.
- Pulses on req_in shorter than one clk period may be lost. Requesters must hold the line at least 2 clk periods.
- Repeated edges on an already-pending line merge into one pending event.
- Ack:
  - ack_valid with pending[ack_idx]=1 and mask[ack_idx]=0 clears pending[ack_idx] on the next edge.
  - Otherwise there is no state change and ack_err pulses high for exactly one cycle (registered).
- Simultaneous new edge and ack on the same bit: set wins, bit stays pending, no ack_err.
- Acks to different bits from new edges proceed independently in the same cycle.
- Mask:
  - mask_wr loads mask on the next edge.
  - Masking does not clear pending; a masked pending bit reappears on pend_vec when unmasked.
  - pend_vec and irq are combinational from the pending and mask flops, so mask changes are visible 1 cycle after mask_wr.
- mask_wr and ack_valid in the same cycle: ack is evaluated against the old mask.
- Level mode (LEVEL_MODE=1): pending[i] = synchronised req bit. Ack never clears pending; ack_err still flags an ack to an unasserted or masked bit.
- Reset mid-operation: all pending events are discarded and mask returns to 8'hFF.
- Outputs settle glitch-free relative to clk: pend_vec only changes after a clk edge.

Optional Feature:
- Macro: IRQ_OVERFLOW_EN.
- When defined:
  - Adds output ovf (8 bits) and input ovf_clr (1 bit).
  - ovf[i] is set sticky when a new rising edge arrives on line i while pending[i] is already 1 and not being cleared in that cycle.
  - ovf_clr pulse clears all ovf bits on the next edge; a set in the same cycle wins.
  - ovf resets to 8'h00.
  - Edge mode only; ovf is held at 0 when LEVEL_MODE=1.
- When undefined: no ovf/ovf_clr ports and no extra flops; behaviour otherwise identical.

Test Plan:
- Reset with req_in=8'h00, then mask_wr with mask_din=8'h00; raise req_in[5] -> pend_vec=8'h20 and irq=1 exactly 3 clk edges after the raise (SYNC_STAGES=2).
- Mask 8'h00, raise req_in bits 7 and 2 together -> pend_vec=8'h84. Then ack_idx=7 -> pend_vec=8'h04 next cycle. Then ack_idx=2 -> pend_vec=8'h00 and irq=0.
- Mask 8'h08 with req_in[3] edge -> pending set but pend_vec=8'h00, irq=0. Ack_idx=3 -> ack_err=1 for one cycle. Write mask 8'h00 -> pend_vec=8'h08.
- Pending[1] set; a new synchronised edge on bit 1 in the same cycle as ack_idx=1 -> pend_vec still 8'h02, ack_err=0. With IRQ_OVERFLOW_EN, ovf stays 8'h00.
- With IRQ_OVERFLOW_EN: pending[4] set, toggle req_in[4] low then high -> ovf=8'h10. ovf_clr pulse -> ovf=8'h00.
- Hold req_in=8'h01 through reset; mask 8'h00 after release -> pend_vec=8'h01. Assert rst_n=0 mid-sequence -> pend_vec=8'h00 and mask_q=8'hFF immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/irq_pending_latch_if.sv
// irq_pending_latch_if: request, mask and acknowledge bundle between the pending latch and its consumer.
// IRQ_OVERFLOW_EN adds the ovf/ovf_clr pair.
interface irq_pending_latch_if;
    logic [7:0] req_in;
    logic       mask_wr;
    logic [7:0] mask_din;
    logic       ack_valid;
    logic [2:0] ack_idx;
    logic [7:0] pend_vec;
    logic       irq;
    logic       ack_err;
    logic [7:0] mask_q;
`ifdef IRQ_OVERFLOW_EN
    logic [7:0] ovf;
    logic       ovf_clr;
    modport master(output req_in, mask_wr, mask_din, ack_valid, ack_idx, ovf_clr,
                   input pend_vec, irq, ack_err, mask_q, ovf);
    modport slave(input req_in, mask_wr, mask_din, ack_valid, ack_idx, ovf_clr,
                  output pend_vec, irq, ack_err, mask_q, ovf);
`else
    modport master(output req_in, mask_wr, mask_din, ack_valid, ack_idx,
                   input pend_vec, irq, ack_err, mask_q);
    modport slave(input req_in, mask_wr, mask_din, ack_valid, ack_idx,
                  output pend_vec, irq, ack_err, mask_q);
`endif
endinterface

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: synchronise 8 request lines, latch rising edges as sticky pending bits under a mask.
// Optional IRQ_OVERFLOW_EN adds sticky per-line overflow flags (ovf) cleared by ovf_clr.
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2,
    parameter bit LEVEL_MODE  = 1'b0
) (
    input logic clk,
    input logic rst_n,
    irq_pending_latch_if.slave bus
);
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] hist_q, pend_q, mask_q, ack_bit, clr, rise, pend_d;
    logic       ack_ok, err_q;
    assign ack_bit = 8'h01 << bus.ack_idx;
    assign ack_ok  = bus.ack_valid & |(ack_bit & pend_q & ~mask_q);
    assign clr     = ack_ok ? ack_bit : 8'h00;
    assign rise    = sync_q[SYNC_STAGES-1] & ~hist_q;
    // a fresh edge overrides a same-cycle ack on that bit
    assign pend_d  = LEVEL_MODE ? sync_q[SYNC_STAGES-1] : rise | (pend_q & ~clr);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 8'h00;
            hist_q <= 8'h00;
            pend_q <= 8'h00;
            mask_q <= 8'hFF;
            err_q  <= 1'b0;
        end else begin
            sync_q[0] <= bus.req_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            hist_q <= sync_q[SYNC_STAGES-1];
            pend_q <= pend_d;
            mask_q <= bus.mask_wr ? bus.mask_din : mask_q;
            err_q  <= bus.ack_valid & ~ack_ok;
        end
    end
    assign bus.pend_vec = pend_q & ~mask_q;
    assign bus.irq      = |bus.pend_vec;
    assign bus.ack_err  = err_q;
    assign bus.mask_q   = mask_q;
`ifdef IRQ_OVERFLOW_EN
    logic [7:0] ovf_q, ovf_set;
    assign ovf_set = LEVEL_MODE ? 8'h00 : rise & pend_q & ~clr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 8'h00;
        else ovf_q <= ovf_set | (bus.ovf_clr ? 8'h00 : ovf_q);
    end
    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: directed plus random stimulus checked every cycle against a sample-history model.
module tb_irq_pending_latch;
    localparam int SS = 2;
    localparam bit LM = 1'b0;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0;
    int bad = 0;
    irq_pending_latch_if bus();
    irq_pending_latch #(.SYNC_STAGES(SS), .LEVEL_MODE(LM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;

    // model: the synchroniser output at an edge is simply req_in as sampled SS edges earlier
    logic [7:0] samp[$];
    logic [7:0] m_pend = 8'h00, m_mask = 8'hFF, m_ovf = 8'h00, m_s, m_h, m_rise, m_clr;
    logic       m_err = 1'b0, m_ok;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp = {};
            for (int i = 0; i < SS + 2; i++) samp.push_front(8'h00);
            m_pend = 8'h00;
            m_mask = 8'hFF;
            m_err  = 1'b0;
            m_ovf  = 8'h00;
        end else begin
            samp.push_front(bus.req_in);
            m_s    = samp[SS];
            m_h    = samp[SS+1];
            void'(samp.pop_back());
            m_rise = m_s & ~m_h;
            m_ok   = bus.ack_valid && m_pend[bus.ack_idx] && !m_mask[bus.ack_idx];
            m_clr  = m_ok ? (8'h01 << bus.ack_idx) : 8'h00;
            m_err  = bus.ack_valid && !m_ok;
`ifdef IRQ_OVERFLOW_EN
            m_ovf  = LM ? 8'h00 : ((m_rise & m_pend & ~m_clr) | (bus.ovf_clr ? 8'h00 : m_ovf));
`endif
            m_pend = LM ? m_s : (m_rise | (m_pend & ~m_clr));
            if (bus.mask_wr) m_mask = bus.mask_din;
        end
    end

    task automatic cmp(input string n, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("model_pend_vec", bus.pend_vec, m_pend & ~m_mask);
        cmp("model_irq", {7'd0, bus.irq}, {7'd0, |(m_pend & ~m_mask)});
        cmp("model_ack_err", {7'd0, bus.ack_err}, {7'd0, m_err});
        cmp("model_mask_q", bus.mask_q, m_mask);
`ifdef IRQ_OVERFLOW_EN
        cmp("model_ovf", bus.ovf, m_ovf);
`endif
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr_mask(input logic [7:0] v);
        bus.mask_wr = 1'b1;
        bus.mask_din = v;
        step();
        bus.mask_wr = 1'b0;
    endtask

    task automatic ack(input logic [2:0] i);
        bus.ack_valid = 1'b1;
        bus.ack_idx = i;
        step();
        bus.ack_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] pv;
        logic [2:0] hi;
        bus.req_in = 8'h00;
        bus.mask_wr = 1'b0;
        bus.mask_din = 8'h00;
        bus.ack_valid = 1'b0;
        bus.ack_idx = 3'd0;
`ifdef IRQ_OVERFLOW_EN
        bus.ovf_clr = 1'b0;
`endif
        #1 rst_n = 1'b0;
        step(3);
        cmp("rst_pend_vec", bus.pend_vec, 8'h00);
        cmp("rst_mask_q", bus.mask_q, 8'hFF);
        cmp("rst_irq", {7'd0, bus.irq}, 8'h00);
        rst_n = 1'b1;
        wr_mask(8'h00);
        cmp("mask_clear", bus.mask_q, 8'h00);
        // SS+1 edge latency
        bus.req_in[5] = 1'b1;
        step();
        cmp("lat_edge1", bus.pend_vec, 8'h00);
        step();
        cmp("lat_edge2", bus.pend_vec, 8'h00);
        step();
        cmp("lat_edge3", bus.pend_vec, 8'h20);
        cmp("lat_irq", {7'd0, bus.irq}, 8'h01);
        ack(3'd5);
        bus.req_in[5] = 1'b0;
        step(3);
        bus.req_in = 8'h84;
        step(3);
        cmp("two_pend", bus.pend_vec, 8'h84);
        ack(3'd7);
        cmp("ack7", bus.pend_vec, 8'h04);
        ack(3'd2);
        cmp("ack2", bus.pend_vec, 8'h00);
        cmp("ack2_irq", {7'd0, bus.irq}, 8'h00);
        bus.req_in = 8'h00;
        step(3);
        // masked pending bit
        wr_mask(8'h08);
        bus.req_in[3] = 1'b1;
        step(3);
        cmp("masked_pend", bus.pend_vec, 8'h00);
        cmp("masked_irq", {7'd0, bus.irq}, 8'h00);
        ack(3'd3);
        cmp("masked_ack_err", {7'd0, bus.ack_err}, 8'h01);
        step();
        cmp("ack_err_pulse", {7'd0, bus.ack_err}, 8'h00);
        wr_mask(8'h00);
        cmp("unmask", bus.pend_vec, 8'h08);
        ack(3'd3);
        bus.req_in[3] = 1'b0;
        step(3);
        // new edge coinciding with ack on the same pending bit
        bus.req_in[1] = 1'b1;
        step(3);
        bus.req_in[1] = 1'b0;
        step(3);
        bus.req_in[1] = 1'b1;
        step(2);
        ack(3'd1);
        cmp("set_wins", bus.pend_vec, 8'h02);
        cmp("set_wins_err", {7'd0, bus.ack_err}, 8'h00);
`ifdef IRQ_OVERFLOW_EN
        cmp("set_wins_ovf", bus.ovf, 8'h00);
`endif
        ack(3'd1);
        bus.req_in[1] = 1'b0;
        step(3);
`ifdef IRQ_OVERFLOW_EN
        bus.req_in[4] = 1'b1;
        step(3);
        bus.req_in[4] = 1'b0;
        step(3);
        bus.req_in[4] = 1'b1;
        step(3);
        cmp("ovf_set", bus.ovf, 8'h10);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        cmp("ovf_clr", bus.ovf, 8'h00);
        ack(3'd4);
        bus.req_in[4] = 1'b0;
        step(3);
`endif
        // line high across reset release counts as one edge
        rst_n = 1'b0;
        bus.req_in = 8'h01;
        step(2);
        rst_n = 1'b1;
        wr_mask(8'h00);
        step(3);
        cmp("held_thru_rst", bus.pend_vec, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst_pend", bus.pend_vec, 8'h00);
        cmp("async_rst_mask", bus.mask_q, 8'hFF);
        step(2);
        rst_n = 1'b1;
        bus.req_in = 8'h00;
        step(3);
        // random traffic, mostly acking the highest visible line
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req_in[$urandom_range(0, 7)] ^= 1'b1;
            bus.mask_wr = ($urandom_range(0, 15) == 0);
            bus.mask_din = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            pv = m_pend & ~m_mask;
            hi = 3'd0;
            for (int i = 0; i < 8; i++) if (pv[i]) hi = 3'(i);
            bus.ack_valid = ($urandom_range(0, 2) == 0);
            bus.ack_idx = ($urandom_range(0, 9) < 7) ? hi : 3'($urandom_range(0, 7));
`ifdef IRQ_OVERFLOW_EN
            bus.ovf_clr = ($urandom_range(0, 15) == 0);
`endif
            step();
        end
        bus.ack_valid = 1'b0;
        bus.mask_wr = 1'b0;
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
